// File: rtl/pio_led_pkg.sv
// Shared constants for the LED PIO slave: bus width and the word address map.
package pio_led_pkg;
    localparam int DATA_BUS_W = 32;
    localparam int ADDR_W     = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CLR    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 3'd5;
endpackage

// File: rtl/pio_led_ctrl_if.sv
// Avalon-MM slave port of the LED PIO.
// Zero-wait-state: a write is accepted whenever chipselect=1 and write_n=0 and lands
// on the next clk edge; readdata is valid combinationally whenever address is stable.
interface pio_led_ctrl_if;
    import pio_led_pkg::*;

    logic [ADDR_W-1:0]     address;
    logic                  chipselect;
    logic                  write_n;
    logic [DATA_BUS_W-1:0] writedata;
    logic [DATA_BUS_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_blink_prescaler.sv
// Blink prescaler: counts 0..period then toggles phase; restart forces cnt and phase to 0.
module led_blink_prescaler #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic [PERIOD_W-1:0] cnt,
    output logic                phase
);

    // Restart wins over the terminal-count toggle so a period rewrite is deterministic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt >= period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/pio_led_ctrl.sv
// Avalon-MM LED output PIO with atomic set/clear, per-bit blink and blink prescaler.
// Optional PWM dimming via the PIO_LED_PWM_EN macro (DUTY register at word 5).
module pio_led_ctrl
    import pio_led_pkg::*;
#(
    parameter int                  WIDTH          = 18,
    parameter int                  PERIOD_W       = 24,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = PERIOD_W'(12_500_000)
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_led_ctrl_if.slave     bus,
    output logic [WIDTH-1:0]  out_port,
    output logic              blink_phase
);

    logic                wr;
    logic [WIDTH-1:0]    wd;
    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    blink_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt;
    logic                restart;
    logic                phase;
    logic                pwm_on;
    logic [DATA_BUS_W-1:0] rdata;
    logic                unused_bits;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign wd          = bus.writedata[WIDTH-1:0];
    assign restart     = wr && (bus.address == ADDR_PERIOD);
    assign unused_bits = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            blink_q  <= '0;
            period_q <= DEFAULT_PERIOD;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:   data_q   <= wd;
                ADDR_BLINK:  blink_q  <= wd;
                ADDR_SET:    data_q   <= data_q | wd;
                ADDR_CLR:    data_q   <= data_q & ~wd;
                ADDR_PERIOD: period_q <= bus.writedata[PERIOD_W-1:0];
                default:     ;
            endcase
        end
    end

    led_blink_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (restart),
        .cnt     (cnt),
        .phase   (phase)
    );

`ifdef PIO_LED_PWM_EN
    logic [7:0] duty_q;
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q  <= 8'hFF;
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (wr && (bus.address == ADDR_DUTY))
                duty_q <= bus.writedata[7:0];
        end
    end

    // Full scale is special-cased so DUTY=255 means always on, not 255/256.
    assign pwm_on = (duty_q == 8'hFF) | (pwm_cnt < duty_q);
`else
    assign pwm_on = 1'b1;
`endif

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:   rdata[WIDTH-1:0]    = data_q;
            ADDR_BLINK:  rdata[WIDTH-1:0]    = blink_q;
            ADDR_PERIOD: rdata[PERIOD_W-1:0] = period_q;
`ifdef PIO_LED_PWM_EN
            ADDR_DUTY:   rdata[7:0]          = duty_q;
`endif
            default:     rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign blink_phase  = phase;
    assign out_port     = data_q & (~blink_q | {WIDTH{phase}}) & {WIDTH{pwm_on}};

endmodule
